pga_serial_ctrl: RTL and testbench

Parametrised serial controller for a bank of NUM_CH programmable-gain amplifiers sharing one data/clock pair, with one active-low chip select per channel. Accepts offset-trim, gain, and measure-mode commands over a valid/ready handshake. Serialises each command as an opcode+payload packet. Runs entirely in the clk50 domain, using a clock-enable tick rather than a derived clock. Sits between the register/Wishbone decode and the PGA pins.

---
 rtl/pga_pkg.sv | 31 +++
 rtl/pga_serial_ctrl_if.sv | 28 ++
 rtl/pga_tick_gen.sv | 30 +++
 rtl/pga_serial_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_pga_serial_ctrl.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pga_pkg.sv
// Shared opcodes, FSM encoding and packet builder for the PGA serial controller.
package pga_pkg;

  localparam logic [1:0] OP_RSVD    = 2'b00;
  localparam logic [1:0] OP_MEASURE = 2'b01;
  localparam logic [1:0] OP_VOS     = 2'b10;
  localparam logic [1:0] OP_GAIN    = 2'b11;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    SHIFT = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
  } pga_state_e;

  // Opcode lands in the top two bits of a pkt_w-wide frame; payload is zero-extended below it.
  function automatic logic [31:0] pga_build_packet(input logic [1:0]  op,
                                                   input logic [31:0] offset,
                                                   input logic [31:0] gain,
                                                   input int          pkt_w);
    logic [31:0] payload;
    case (op)
      OP_VOS:  payload = offset;
      OP_GAIN: payload = gain;
      default: payload = 32'd0;
    endcase
    return ({30'd0, op} << (pkt_w - 2)) | payload;
  endfunction

endpackage

// File: rtl/pga_serial_ctrl_if.sv
// Command handshake bundle between the register decode and the PGA serial controller.
interface pga_serial_ctrl_if #(
  parameter int NUM_CH   = 4,
  parameter int OFFSET_W = 5,
  parameter int GAIN_W   = 4
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [CH_W-1:0]     cmd_ch;
  logic                cmd_bcast;
  logic [OFFSET_W-1:0] offset;
  logic [GAIN_W-1:0]   gain;
  logic                op_complete;
  logic                cmd_err;

  modport master (
    output cmd_valid, cmd_op, cmd_ch, cmd_bcast, offset, gain,
    input  cmd_ready, op_complete, cmd_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_ch, cmd_bcast, offset, gain,
    output cmd_ready, op_complete, cmd_err
  );
endinterface

// File: rtl/pga_tick_gen.sv
// Clock-enable divider: one tick every CLK_DIV cycles while run is high, phase reset to 0 otherwise.
module pga_tick_gen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk50,
  input  logic wb_rst_n,
  input  logic run,
  output logic tick
);
  localparam int             CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_r;

  // Divider counter, parked at zero whenever the controller is not mid-frame.
  always_ff @(posedge clk50 or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (!run) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign tick = run && (cnt_r == CNT_LAST);

endmodule

// File: rtl/pga_serial_ctrl.sv
// Serialises offset/gain/measure commands to a bank of PGAs over a shared data/clock pair.
module pga_serial_ctrl
  import pga_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CLK_DIV  = 5,
  parameter int OFFSET_W = 5,
  parameter int GAIN_W   = 4,
  parameter int PKT_W    = 8
) (
  input  logic              clk50,
  input  logic              wb_rst_n,
  pga_serial_ctrl_if.slave  cmd,
  output logic              pga_dat,
  output logic              pga_clk,
  output logic [NUM_CH-1:0] pga_cs_n
);
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int              BIT_W    = $clog2(PKT_W);
  localparam logic [CH_W:0]   NUM_CH_L = NUM_CH[CH_W:0];
  localparam logic [BIT_W-1:0] BIT_MSB = BIT_W'(PKT_W - 1);

  pga_state_e        state_r, state_nx;
  logic [PKT_W-1:0]  pkt_r, pkt_nx;
  logic [BIT_W-1:0]  bit_r, bit_nx;
  logic              phase_r, phase_nx;
  logic              ready_r, ready_nx;
  logic              done_r, done_nx;
  logic              err_r, err_nx;
  logic              dat_r, dat_nx;
  logic              sclk_r, sclk_nx;
  logic [NUM_CH-1:0] cs_r, cs_nx;

  logic              accept_s;
  logic              bad_s;
  logic              run_s;
  logic              tick_s;
  logic [NUM_CH-1:0] sel_s;
  logic [PKT_W-1:0]  pkt_new_s;

  assign accept_s  = cmd.cmd_valid && ready_r;
  assign bad_s     = (cmd.cmd_op == OP_RSVD) ||
                     (!cmd.cmd_bcast && ({1'b0, cmd.cmd_ch} >= NUM_CH_L));
  assign pkt_new_s = PKT_W'(pga_build_packet(cmd.cmd_op, 32'(cmd.offset),
                                             32'(cmd.gain), PKT_W));
  assign run_s     = (state_r == SETUP) || (state_r == SHIFT) || (state_r == HOLD);

  pga_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk50    (clk50),
    .wb_rst_n (wb_rst_n),
    .run      (run_s),
    .tick     (tick_s)
  );

  // Active-high channel select mask for the incoming command.
  always_comb begin
    sel_s = {NUM_CH{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      sel_s[i] = cmd.cmd_bcast || (cmd.cmd_ch == CH_W'(i));
    end
  end

  // Next-state and next-pin logic; every pin is registered below so the PGA sees no glitches.
  always_comb begin
    state_nx = state_r;
    pkt_nx   = pkt_r;
    bit_nx   = bit_r;
    phase_nx = phase_r;
    ready_nx = ready_r;
    done_nx  = 1'b0;
    err_nx   = 1'b0;
    dat_nx   = dat_r;
    sclk_nx  = sclk_r;
    cs_nx    = cs_r;

    case (state_r)
      IDLE, DONE: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        if (accept_s) begin
          if (bad_s) begin
            err_nx = 1'b1;
          end else begin
            state_nx = SETUP;
            ready_nx = 1'b0;
            pkt_nx   = pkt_new_s;
            bit_nx   = BIT_MSB;
            phase_nx = 1'b0;
            cs_nx    = ~sel_s;
            dat_nx   = pkt_new_s[PKT_W-1];
          end
        end else begin
          err_nx = 1'b0;
        end
      end

      SETUP: begin
        if (tick_s) begin
          state_nx = SHIFT;
        end else begin
          state_nx = SETUP;
        end
      end

      // Two ticks per bit: rise on the first, fall and advance data on the second.
      SHIFT: begin
        if (tick_s) begin
          if (!phase_r) begin
            sclk_nx  = 1'b1;
            phase_nx = 1'b1;
          end else begin
            sclk_nx  = 1'b0;
            phase_nx = 1'b0;
            if (bit_r == {BIT_W{1'b0}}) begin
              state_nx = HOLD;
            end else begin
              bit_nx = bit_r - {{(BIT_W-1){1'b0}}, 1'b1};
              pkt_nx = {pkt_r[PKT_W-2:0], 1'b0};
              dat_nx = pkt_r[PKT_W-2];
            end
          end
        end else begin
          state_nx = SHIFT;
        end
      end

      HOLD: begin
        if (tick_s) begin
          state_nx = DONE;
          cs_nx    = {NUM_CH{1'b1}};
          dat_nx   = 1'b0;
          done_nx  = 1'b1;
          ready_nx = 1'b1;
        end else begin
          state_nx = HOLD;
        end
      end

      default: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        cs_nx    = {NUM_CH{1'b1}};
        dat_nx   = 1'b0;
        sclk_nx  = 1'b0;
        phase_nx = 1'b0;
      end
    endcase
  end

  // State, packet and output registers; reset drops all pins to idle immediately.
  always_ff @(posedge clk50 or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_r <= IDLE;
      pkt_r   <= {PKT_W{1'b0}};
      bit_r   <= {BIT_W{1'b0}};
      phase_r <= 1'b0;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      dat_r   <= 1'b0;
      sclk_r  <= 1'b0;
      cs_r    <= {NUM_CH{1'b1}};
    end else begin
      state_r <= state_nx;
      pkt_r   <= pkt_nx;
      bit_r   <= bit_nx;
      phase_r <= phase_nx;
      ready_r <= ready_nx;
      done_r  <= done_nx;
      err_r   <= err_nx;
      dat_r   <= dat_nx;
      sclk_r  <= sclk_nx;
      cs_r    <= cs_nx;
    end
  end

  assign cmd.cmd_ready   = ready_r;
  assign cmd.op_complete = done_r;
  assign cmd.cmd_err     = err_r;
  assign pga_dat         = dat_r;
  assign pga_clk         = sclk_r;
  assign pga_cs_n        = cs_r;

endmodule

// File: tb/tb_pga_serial_ctrl.sv
// Directed bench for pga_serial_ctrl: default instance (4 ch, CLK_DIV=5) and a fast 5-channel instance.
module tb_pga_serial_ctrl;

  logic clk50    = 1'b0;
  logic wb_rst_n = 1'b0;
  always #10 clk50 = ~clk50;

  pga_serial_ctrl_if #(.NUM_CH(4)) a_if ();
  pga_serial_ctrl_if #(.NUM_CH(5)) b_if ();

  logic       a_dat, a_clk;
  logic [3:0] a_cs;
  logic       b_dat, b_clk;
  logic [4:0] b_cs;

  pga_serial_ctrl dut_a (
    .clk50(clk50), .wb_rst_n(wb_rst_n), .cmd(a_if),
    .pga_dat(a_dat), .pga_clk(a_clk), .pga_cs_n(a_cs)
  );

  pga_serial_ctrl #(.NUM_CH(5), .CLK_DIV(1)) dut_b (
    .clk50(clk50), .wb_rst_n(wb_rst_n), .cmd(b_if),
    .pga_dat(b_dat), .pga_clk(b_clk), .pga_cs_n(b_cs)
  );

  int   cyc = 0;
  logic bits_a[$];
  logic bits_b[$];
  int   rises_a = 0;
  int   rises_b = 0;

  always @(posedge clk50) cyc <= cyc + 1;
  always @(posedge a_clk) begin bits_a.push_back(a_dat); rises_a <= rises_a + 1; end
  always @(posedge b_clk) begin bits_b.push_back(b_dat); rises_b <= rises_b + 1; end

  int n_checks = 0;
  int n_fail   = 0;
  int t_acc    = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input bit sel, input logic [1:0] op, input logic [3:0] ch,
                       input bit bc, input logic [4:0] off, input logic [3:0] gn);
    @(negedge clk50);
    if (!sel) begin
      a_if.cmd_op = op; a_if.cmd_ch = ch[1:0]; a_if.cmd_bcast = bc;
      a_if.offset = off; a_if.gain = gn; a_if.cmd_valid = 1'b1;
    end else begin
      b_if.cmd_op = op; b_if.cmd_ch = ch[2:0]; b_if.cmd_bcast = bc;
      b_if.offset = off; b_if.gain = gn; b_if.cmd_valid = 1'b1;
    end
    @(posedge clk50);
    #1;
    t_acc = cyc;
    a_if.cmd_valid = 1'b0;
    b_if.cmd_valid = 1'b0;
  endtask

  // Waits for op_complete; returns latency from accept (-1 on timeout) and busy cycles with ready high.
  task automatic run_packet(input bit sel, input int budget, output int lat,
                            output int rdy_busy, output logic [4:0] cs_first);
    lat = -1; rdy_busy = 0; cs_first = 5'h1F;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk50);
      if (i == 0) cs_first = sel ? b_cs : {1'b1, a_cs};
      if (sel ? b_if.op_complete : a_if.op_complete) begin
        lat = cyc - t_acc;
        break;
      end
      if (sel ? b_if.cmd_ready : a_if.cmd_ready) rdy_busy++;
    end
  endtask

  task automatic bits_val(input bit sel, output int n, output logic [7:0] v);
    v = 8'h00;
    if (!sel) begin
      n = bits_a.size();
      foreach (bits_a[i]) v = {v[6:0], bits_a[i]};
    end else begin
      n = bits_b.size();
      foreach (bits_b[i]) v = {v[6:0], bits_b[i]};
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  int         lat, rb, nb, bad, r0;
  logic [4:0] csf;
  logic [7:0] bv;

  initial begin
    a_if.cmd_valid = 1'b0; a_if.cmd_op = 2'b00; a_if.cmd_ch = 2'd0; a_if.cmd_bcast = 1'b0;
    a_if.offset = 5'd0; a_if.gain = 4'd0;
    b_if.cmd_valid = 1'b0; b_if.cmd_op = 2'b00; b_if.cmd_ch = 3'd0; b_if.cmd_bcast = 1'b0;
    b_if.offset = 5'd0; b_if.gain = 4'd0;
    repeat (3) @(negedge clk50);
    wb_rst_n = 1'b1;

    // Idle after reset release
    check_val("rst_cs", {28'd0, a_cs}, 32'hF);
    check_val("rst_ready", {31'd0, a_if.cmd_ready}, 32'd1);
    bad = 0;
    repeat (200) begin
      @(negedge clk50);
      if (a_cs !== 4'hF || a_clk !== 1'b0 || a_dat !== 1'b0 || a_if.cmd_ready !== 1'b1 ||
          a_if.op_complete !== 1'b0 || a_if.cmd_err !== 1'b0 || b_cs !== 5'h1F || b_clk !== 1'b0)
        bad++;
    end
    check_val("idle_200", bad, 0);

    // set_vos ch2 offset 0x13 -> 8'b10010011
    bits_a.delete();
    issue(1'b0, 2'b10, 4'd2, 1'b0, 5'h13, 4'h0);
    run_packet(1'b0, 200, lat, rb, csf);
    check_val("vos_cs", {27'd0, csf}, 32'h1B);
    check_val("vos_lat", lat, 90);
    check_val("vos_busy_ready", rb, 0);
    check_val("vos_done_ready", {31'd0, a_if.cmd_ready}, 32'd1);
    bits_val(1'b0, nb, bv);
    check_val("vos_nbits", nb, 8);
    check_val("vos_bits", {24'd0, bv}, 32'h93);
    @(negedge clk50);
    check_val("vos_done_pulse", {31'd0, a_if.op_complete}, 32'd0);
    check_val("vos_cs_idle", {28'd0, a_cs}, 32'hF);

    // set_gain broadcast 0xA, CLK_DIV=1 -> 8'b11001010
    bits_b.delete();
    issue(1'b1, 2'b11, 4'd0, 1'b1, 5'h00, 4'hA);
    run_packet(1'b1, 100, lat, rb, csf);
    check_val("gain_bc_cs", {27'd0, csf}, 32'h00);
    check_val("gain_bc_lat", lat, 18);
    bits_val(1'b1, nb, bv);
    check_val("gain_bc_nbits", nb, 8);
    check_val("gain_bc_bits", {24'd0, bv}, 32'hCA);

    // Highest valid channel (4 of 5) measure
    bits_b.delete();
    issue(1'b1, 2'b01, 4'd4, 1'b0, 5'h1F, 4'hF);
    run_packet(1'b1, 100, lat, rb, csf);
    check_val("meas_ch4_cs", {27'd0, csf}, 32'h0F);
    check_val("meas_ch4_lat", lat, 18);
    bits_val(1'b1, nb, bv);
    check_val("meas_ch4_bits", {24'd0, bv}, 32'h40);

    // Reserved opcode rejected
    r0 = rises_a;
    issue(1'b0, 2'b00, 4'd1, 1'b0, 5'h03, 4'h3);
    @(negedge clk50);
    check_val("rsvd_err", {31'd0, a_if.cmd_err}, 32'd1);
    check_val("rsvd_ready", {31'd0, a_if.cmd_ready}, 32'd1);
    check_val("rsvd_cs", {28'd0, a_cs}, 32'hF);
    @(negedge clk50);
    check_val("rsvd_err_pulse", {31'd0, a_if.cmd_err}, 32'd0);
    repeat (20) @(negedge clk50);
    check_val("rsvd_no_clk", rises_a - r0, 0);

    // Channel out of range (5 with NUM_CH=5) rejected
    r0 = rises_b;
    issue(1'b1, 2'b10, 4'd5, 1'b0, 5'h07, 4'h0);
    @(negedge clk50);
    check_val("badch_err", {31'd0, b_if.cmd_err}, 32'd1);
    check_val("badch_ready", {31'd0, b_if.cmd_ready}, 32'd1);
    check_val("badch_cs", {27'd0, b_cs}, 32'h1F);
    repeat (10) @(negedge clk50);
    check_val("badch_no_clk", rises_b - r0, 0);

    // Measure ch0 with a second command held valid mid-packet
    bits_a.delete();
    issue(1'b0, 2'b01, 4'd0, 1'b0, 5'h1F, 4'hF);
    repeat (30) @(negedge clk50);
    a_if.cmd_op = 2'b10; a_if.cmd_ch = 2'd1; a_if.cmd_bcast = 1'b0;
    a_if.offset = 5'h0A; a_if.gain = 4'h0; a_if.cmd_valid = 1'b1;
    run_packet(1'b0, 200, lat, rb, csf);
    check_val("b2b_first_lat", lat, 90);
    check_val("b2b_busy_ready", rb, 0);
    bits_val(1'b0, nb, bv);
    check_val("b2b_first_nbits", nb, 8);
    check_val("b2b_first_bits", {24'd0, bv}, 32'h40);
    bits_a.delete();
    @(negedge clk50);
    a_if.cmd_valid = 1'b0;
    t_acc = cyc;
    check_val("b2b_second_ready", {31'd0, a_if.cmd_ready}, 32'd0);
    check_val("b2b_second_cs", {28'd0, a_cs}, 32'hD);
    check_val("b2b_done_pulse", {31'd0, a_if.op_complete}, 32'd0);
    run_packet(1'b0, 200, lat, rb, csf);
    check_val("b2b_second_lat", lat, 90);
    bits_val(1'b0, nb, bv);
    check_val("b2b_second_bits", {24'd0, bv}, 32'h8A);

    // Async reset during bit 4 of gain ch3 0x5 (8'b11000101)
    bits_a.delete();
    issue(1'b0, 2'b11, 4'd3, 1'b0, 5'h00, 4'h5);
    repeat (42) @(negedge clk50);
    check_val("rst_mid_clk_high", {31'd0, a_clk}, 32'd1);
    bits_val(1'b0, nb, bv);
    check_val("rst_mid_nbits", nb, 4);
    check_val("rst_mid_bits", {24'd0, bv}, 32'h0C);
    #3;
    wb_rst_n = 1'b0;
    #1;
    check_val("rst_async_pins", {26'd0, a_cs, a_clk, a_dat}, {26'd0, 4'hF, 1'b0, 1'b0});
    bad = 0;
    repeat (3) begin
      @(negedge clk50);
      if (a_if.op_complete !== 1'b0) bad++;
    end
    wb_rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk50);
      if (a_if.op_complete !== 1'b0 || a_clk !== 1'b0 || a_cs !== 4'hF) bad++;
    end
    check_val("rst_no_complete", bad, 0);
    bits_a.delete();
    issue(1'b0, 2'b11, 4'd3, 1'b0, 5'h00, 4'h5);
    run_packet(1'b0, 200, lat, rb, csf);
    check_val("post_rst_cs", {27'd0, csf}, 32'h17);
    check_val("post_rst_lat", lat, 90);
    bits_val(1'b0, nb, bv);
    check_val("post_rst_bits", {24'd0, bv}, 32'hC5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
